// File: rtl/mac_pkg.sv
// Shared definitions for the MAC issue/retire controller: rounding-mode
// encodings, fflags bit positions, controller FSM states and rm legality.
package mac_pkg;

  localparam int unsigned RM_W  = 3;
  localparam int unsigned FLG_W = 5;

  localparam logic [RM_W-1:0] RM_RNE = 3'b000;
  localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
  localparam logic [RM_W-1:0] RM_RDN = 3'b010;
  localparam logic [RM_W-1:0] RM_RUP = 3'b011;
  localparam logic [RM_W-1:0] RM_RMM = 3'b100;
  localparam logic [RM_W-1:0] RM_DYN = 3'b111;

  // Flags are packed {NV,DZ,OF,UF,NX}, NX in bit 0
  localparam int unsigned FLG_NX = 0;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_DZ = 3;
  localparam int unsigned FLG_NV = 4;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } mac_state_e;

  // A resolved rounding mode is usable only in the RNE..RMM range
  function automatic logic rm_legal(input logic [RM_W-1:0] rm);
    return (rm <= RM_RMM);
  endfunction

endpackage

// File: rtl/mac_issue_ctrl_if.sv
// Request, datapath and response signals of mac_issue_ctrl.
// slave: the controller side; master: the requester/datapath/consumer side.
interface mac_issue_ctrl_if #(
  parameter int PARM_TAG   = 5,
  parameter int PARM_RM    = 3,
  parameter int PARM_WIDTH = 32
) ();
  import mac_pkg::*;

  logic                  Req_valid_i;
  logic                  Req_ready_o;
  logic [PARM_RM-1:0]    Req_rm_i;
  logic [PARM_TAG-1:0]   Req_tag_i;
  logic [PARM_RM-1:0]    Frm_i;
  logic                  Flush_i;
  logic                  Issue_valid_o;
  logic [PARM_RM-1:0]    Issue_rm_o;
  logic [PARM_WIDTH-1:0] Dp_result_i;
  logic [FLG_W-1:0]      Dp_flags_i;
  logic                  Rsp_valid_o;
  logic                  Rsp_ready_i;
  logic [PARM_WIDTH-1:0] Rsp_result_o;
  logic [FLG_W-1:0]      Rsp_flags_o;
  logic [PARM_TAG-1:0]   Rsp_tag_o;
  logic                  Rsp_illegal_o;
  logic [FLG_W-1:0]      Fflags_o;
  logic                  Fflags_clr_i;

  modport slave (
    input  Req_valid_i, Req_rm_i, Req_tag_i, Frm_i, Flush_i,
    input  Dp_result_i, Dp_flags_i, Rsp_ready_i, Fflags_clr_i,
    output Req_ready_o, Issue_valid_o, Issue_rm_o,
    output Rsp_valid_o, Rsp_result_o, Rsp_flags_o, Rsp_tag_o, Rsp_illegal_o,
    output Fflags_o
  );

  modport master (
    output Req_valid_i, Req_rm_i, Req_tag_i, Frm_i, Flush_i,
    output Dp_result_i, Dp_flags_i, Rsp_ready_i, Fflags_clr_i,
    input  Req_ready_o, Issue_valid_o, Issue_rm_o,
    input  Rsp_valid_o, Rsp_result_o, Rsp_flags_o, Rsp_tag_o, Rsp_illegal_o,
    input  Fflags_o
  );

endinterface

// File: rtl/mac_rsp_fifo.sv
// Synchronous response FIFO with occupancy count. Flush empties it in one cycle.
module mac_rsp_fifo #(
  parameter int PARM_DEPTH = 4,
  parameter int PARM_DW    = 32
) (
  input  logic                        Clk_i,
  input  logic                        Rst_i,
  input  logic                        Flush_i,
  input  logic                        Wr_en_i,
  input  logic [PARM_DW-1:0]          Wr_data_i,
  input  logic                        Rd_en_i,
  output logic [PARM_DW-1:0]          Rd_data_o,
  output logic                        Rd_valid_o,
  output logic [$clog2(PARM_DEPTH):0] Count_o
);

  localparam int PW = $clog2(PARM_DEPTH);

  logic [PARM_DW-1:0] mem [PARM_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        cnt_q;

  // Pointer and occupancy bookkeeping; simultaneous read and write keep the count
  always_ff @(posedge Clk_i) begin
    if (Rst_i || Flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (Wr_en_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (Rd_en_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({Wr_en_i, Rd_en_i})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, kept free of reset
  always_ff @(posedge Clk_i) begin
    if (Wr_en_i) mem[wr_ptr_q] <= Wr_data_i;
  end

  assign Rd_data_o  = mem[rd_ptr_q];
  assign Rd_valid_o = (cnt_q != '0);
  assign Count_o    = cnt_q;

endmodule

// File: rtl/mac_issue_ctrl.sv
// Issue/retire controller for the fixed-latency FMA datapath.
// Resolves rm, issues only when a response slot is guaranteed, tracks ops in
// order through a PARM_LAT-deep shift register and buffers results in a FIFO.
// Optional sticky fflags accumulator: define MAC_FFLAGS_ACC_EN.
module mac_issue_ctrl #(
  parameter int PARM_LAT   = 4,
  parameter int PARM_DEPTH = 4,
  parameter int PARM_TAG   = 5,
  parameter int PARM_RM    = 3,
  parameter int PARM_WIDTH = 32
) (
  input logic             Clk_i,
  input logic             Rst_i,
  mac_issue_ctrl_if.slave bus
);
  import mac_pkg::*;

  localparam int CW = $clog2(PARM_DEPTH) + 1;
  localparam int IW = $clog2(PARM_LAT + 1);
  localparam int FW = 1 + PARM_TAG + FLG_W + PARM_WIDTH;

  mac_state_e          state_q, state_d;
  logic [IW-1:0]       fcnt_q, fcnt_d;
  logic [PARM_LAT-1:0] trk_vld_q;
  logic [PARM_LAT-1:0] trk_ill_q;
  logic [PARM_TAG-1:0] trk_tag_q [PARM_LAT];
  logic [IW-1:0]       inflight;
  logic [PARM_RM-1:0]  rm_res;
  logic                rm_ok;
  logic                credit_ok;
  logic                req_ready;
  logic                accept;
  logic                exit_vld;
  logic                exit_ill;
  logic                fifo_wr, fifo_rd, fifo_vld;
  logic [FW-1:0]       fifo_wdata, fifo_rdata;
  logic [CW-1:0]       fifo_cnt;

  assign rm_res = (bus.Req_rm_i == PARM_RM'(RM_DYN)) ? bus.Frm_i : bus.Req_rm_i;
  assign rm_ok  = rm_legal(RM_W'(rm_res));

  // Credits: every tracked op already owns a FIFO slot
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < PARM_LAT; i++) inflight += IW'(trk_vld_q[i]);
  end

  assign credit_ok = (32'(inflight) + 32'(fifo_cnt)) < 32'(PARM_DEPTH);

  // Next state, flush countdown and request acceptance
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    req_ready = 1'b0;
    case (state_q)
      ST_RUN: begin
        req_ready = ~bus.Flush_i & credit_ok;
        if (bus.Flush_i) begin
          state_d = ST_FLUSH;
          fcnt_d  = IW'(PARM_LAT - 1);
        end
      end
      ST_FLUSH: begin
        if (bus.Flush_i)        fcnt_d  = IW'(PARM_LAT - 1);
        else if (fcnt_q == '0)  state_d = ST_RUN;
        else                    fcnt_d  = fcnt_q - IW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state and flush counter
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign accept            = bus.Req_valid_i & req_ready;
  assign bus.Req_ready_o   = req_ready;
  assign bus.Issue_valid_o = accept & rm_ok;
  assign bus.Issue_rm_o    = (accept & rm_ok) ? rm_res : '0;

  // Tracker valid bits; a flush squashes everything in flight
  always_ff @(posedge Clk_i) begin
    if (Rst_i || bus.Flush_i) begin
      trk_vld_q <= '0;
    end else begin
      trk_vld_q[0] <= accept;
      for (int unsigned i = 1; i < PARM_LAT; i++) trk_vld_q[i] <= trk_vld_q[i-1];
    end
  end

  // Tracker payload travels alongside the valid bits
  always_ff @(posedge Clk_i) begin
    trk_ill_q[0] <= ~rm_ok;
    trk_tag_q[0] <= bus.Req_tag_i;
    for (int unsigned i = 1; i < PARM_LAT; i++) begin
      trk_ill_q[i] <= trk_ill_q[i-1];
      trk_tag_q[i] <= trk_tag_q[i-1];
    end
  end

  // Last tracker stage lines up with the datapath result; flush wins over the write
  assign exit_vld   = trk_vld_q[PARM_LAT-1] & (state_q == ST_RUN);
  assign exit_ill   = trk_ill_q[PARM_LAT-1];
  assign fifo_wr    = exit_vld & ~bus.Flush_i;
  assign fifo_wdata = {exit_ill, trk_tag_q[PARM_LAT-1],
                       exit_ill ? '0 : bus.Dp_flags_i,
                       exit_ill ? '0 : bus.Dp_result_i};
  assign fifo_rd    = fifo_vld & bus.Rsp_ready_i;

  mac_rsp_fifo #(
    .PARM_DEPTH (PARM_DEPTH),
    .PARM_DW    (FW)
  ) u_rsp_fifo (
    .Clk_i      (Clk_i),
    .Rst_i      (Rst_i),
    .Flush_i    (bus.Flush_i),
    .Wr_en_i    (fifo_wr),
    .Wr_data_i  (fifo_wdata),
    .Rd_en_i    (fifo_rd),
    .Rd_data_o  (fifo_rdata),
    .Rd_valid_o (fifo_vld),
    .Count_o    (fifo_cnt)
  );

  assign bus.Rsp_valid_o = fifo_vld;
  assign {bus.Rsp_illegal_o, bus.Rsp_tag_o, bus.Rsp_flags_o, bus.Rsp_result_o} =
         fifo_vld ? fifo_rdata : '0;

  // Credit scheme guarantees a free slot for every tracker exit
  always_ff @(posedge Clk_i) begin
    if (!Rst_i) assert (!(fifo_wr && !fifo_rd && (fifo_cnt == CW'(PARM_DEPTH))));
  end

`ifdef MAC_FFLAGS_ACC_EN
  logic [FLG_W-1:0] fflags_q;

  // Sticky flags; a response in the clear cycle still lands
  always_ff @(posedge Clk_i) begin
    if (Rst_i)                 fflags_q <= '0;
    else if (fifo_rd)          fflags_q <= (bus.Fflags_clr_i ? '0 : fflags_q) | bus.Rsp_flags_o;
    else if (bus.Fflags_clr_i) fflags_q <= '0;
  end

  assign bus.Fflags_o = fflags_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = bus.Fflags_clr_i;
  assign bus.Fflags_o      = '0;
`endif

endmodule
